// File: rtl/ysyx_210544_rtc_arb.sv
// Two-port round-robin read arbiter for the RTC block. Each transaction issues
// one rtc_ren pulse, captures the RTC value and returns it on a valid/ready
// response channel. A programmable idle gap separates consecutive reads.
module ysyx_210544_rtc_arb #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MIN_GAP = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_data_o,
  output logic              rsp0_err_o,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              rsp1_err_o,

  output logic              rtc_ren_o,
  input  logic [DATA_W-1:0] rtc_rdata_i,
  output logic              busy_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [7:0] GapInit = MIN_GAP[7:0];

  logic [1:0]        state_q, state_d;
  logic [7:0]        gap_q, gap_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              grant;
  logic              can_grant;
  logic              any_req;
  logic              owner_rsp_ready;

  // Pick the requester: a lone valid port wins, a tie goes to the port not served last.
  always_comb begin
    any_req   = req0_valid_i | req1_valid_i;
    can_grant = (state_q == StIdle) && (gap_q == 8'd0);
    if (req0_valid_i && req1_valid_i) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid_i;
    end
  end

  // Request/response handshake outputs; only the owner sees a response.
  always_comb begin
    req0_ready_o    = can_grant & req0_valid_i & ~grant;
    req1_ready_o    = can_grant & req1_valid_i & grant;
    rtc_ren_o       = (state_q == StRead);
    rsp0_valid_o    = (state_q == StResp) & ~owner_q;
    rsp1_valid_o    = (state_q == StResp) & owner_q;
    rsp0_data_o     = data_q;
    rsp1_data_o     = data_q;
    rsp0_err_o      = rsp0_valid_o & err_q;
    rsp1_err_o      = rsp1_valid_o & err_q;
    busy_o          = (state_q != StIdle) || (gap_q != 8'd0);
    owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;
  end

  // Sequencer next state: IDLE -> READ -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    gap_d        = gap_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    data_d       = data_q;
    err_d        = err_q;
    case (state_q)
      StIdle: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (any_req) begin
          // The granted port's ready is high, so any valid request completes a handshake.
          owner_d = grant;
          state_d = StRead;
        end
      end
      StRead: begin
        data_d  = rtc_rdata_i;
        err_d   = (rtc_rdata_i == '0);
        state_d = StResp;
      end
      StResp: begin
        if (owner_rsp_ready) begin
          state_d      = StIdle;
          last_grant_d = owner_q;
          gap_d        = GapInit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any in-flight read.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      gap_q        <= 8'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

endmodule
